// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: shared constants for the return-address stack.
//   PC_STACK_DEPTH  default number of return-address entries
//   PC_STACK_AW     default return-address width
//   PC_STACK_PTR_W  top-pointer width for the default depth
//   ptrW()/cntW()   pointer/count widths for an arbitrary depth
package pc_stack_pkg;

    localparam int PC_STACK_DEPTH = 8;
    localparam int PC_STACK_AW    = 12;
    localparam int PC_STACK_PTR_W = $clog2(PC_STACK_DEPTH);

    function automatic int ptrW(input int depth);
        return $clog2(depth);
    endfunction

    // count must reach DEPTH itself, so one bit wider than the pointer
    function automatic int cntW(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// pc_stack_if: call/return port of the PC stack.
//   master drives push/pop/pushData (the sequencer),
//   slave (the stack) returns popData/empty/full/count.
// Optional macro PC_STACK_OVF_TRAP_EN adds sticky overflow/underflow flags.
interface pc_stack_if
    import pc_stack_pkg::*;
#(
    parameter int DEPTH = PC_STACK_DEPTH,
    parameter int AW    = PC_STACK_AW
);
    logic                     push;
    logic                     pop;
    logic [AW-1:0]            pushData;
    logic [AW-1:0]            popData;
    logic                     empty;
    logic                     full;
    logic [cntW(DEPTH)-1:0]   count;
`ifdef PC_STACK_OVF_TRAP_EN
    logic                     overflow;
    logic                     underflow;
`endif

    modport master (
        output push, pop, pushData,
`ifdef PC_STACK_OVF_TRAP_EN
        input  overflow, underflow,
`endif
        input  popData, empty, full, count
    );

    modport slave (
        input  push, pop, pushData,
`ifdef PC_STACK_OVF_TRAP_EN
        output overflow, underflow,
`endif
        output popData, empty, full, count
    );

endinterface

// File: rtl/pc_stack_regfile.sv
// stack_regfile: entry storage for pc_stack.
//   clock  write clock
//   we/wAddr/wData  synchronous write port
//   rAddr/rData     asynchronous read port
// No reset: entries are unobservable until written.
module stack_regfile
    import pc_stack_pkg::*;
#(
    parameter int DEPTH = PC_STACK_DEPTH,
    parameter int AW    = PC_STACK_AW
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [ptrW(DEPTH)-1:0] wAddr,
    input  logic [AW-1:0]          wData,
    input  logic [ptrW(DEPTH)-1:0] rAddr,
    output logic [AW-1:0]          rData
);

    logic [DEPTH-1:0][AW-1:0] mem;

    always_ff @(posedge clock) begin
        if (we) mem[wAddr] <= wData;
    end

    assign rData = mem[rAddr];

endmodule

// File: rtl/pc_stack.sv
// pc_stack: circular-buffer return-address stack with zero-latency pop.
//   clock        rising-edge clock
//   init_signal  asynchronous active-high reset
//   bus          pc_stack_if.slave (push/pop/pushData in,
//                popData/empty/full/count[/overflow/underflow] out)
// Macro PC_STACK_OVF_TRAP_EN: push-when-full and pop-when-empty are ignored
// and latch sticky flags. Without it, push-when-full overwrites the oldest
// entry (the ring just keeps turning with count pinned at DEPTH).
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int DEPTH = PC_STACK_DEPTH,
    parameter int AW    = PC_STACK_AW
) (
    input logic       clock,
    input logic       init_signal,
    pc_stack_if.slave bus
);

    localparam int PW = ptrW(DEPTH);
    localparam int CW = cntW(DEPTH);

    logic [PW-1:0] tp, tpNext, tpPrev;
    logic [CW-1:0] cnt, cntNext;
    logic          isEmpty, isFull;
    logic          we;
    logic [PW-1:0] wAddr;
    logic [AW-1:0] rData;
`ifdef PC_STACK_OVF_TRAP_EN
    logic          ovfSet, unfSet, ovfQ, unfQ;
`endif

    // power-of-two depth: pointer arithmetic wraps for free
    assign tpPrev  = tp - PW'(1);
    assign isEmpty = (cnt == '0);
    assign isFull  = (cnt == CW'(DEPTH));

    always_comb begin
        tpNext  = tp;
        cntNext = cnt;
        we      = 1'b0;
        wAddr   = tp;
`ifdef PC_STACK_OVF_TRAP_EN
        ovfSet  = 1'b0;
        unfSet  = 1'b0;
`endif
        if (bus.push && bus.pop && !isEmpty) begin
            // call+return in one cycle: replace top in place
            we    = 1'b1;
            wAddr = tpPrev;
        end else if (bus.push) begin
            if (!isFull) begin
                we      = 1'b1;
                tpNext  = tp + PW'(1);
                cntNext = cnt + CW'(1);
            end else begin
`ifdef PC_STACK_OVF_TRAP_EN
                ovfSet = 1'b1;
`else
                we     = 1'b1;
                tpNext = tp + PW'(1);
`endif
            end
        end else if (bus.pop) begin
            if (!isEmpty) begin
                tpNext  = tpPrev;
                cntNext = cnt - CW'(1);
            end else begin
`ifdef PC_STACK_OVF_TRAP_EN
                unfSet = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge init_signal) begin
        if (init_signal) begin
            tp  <= '0;
            cnt <= '0;
        end else begin
            tp  <= tpNext;
            cnt <= cntNext;
        end
    end

`ifdef PC_STACK_OVF_TRAP_EN
    always_ff @(posedge clock or posedge init_signal) begin
        if (init_signal) begin
            ovfQ <= 1'b0;
            unfQ <= 1'b0;
        end else begin
            ovfQ <= ovfQ | ovfSet;
            unfQ <= unfQ | unfSet;
        end
    end
    assign bus.overflow  = ovfQ;
    assign bus.underflow = unfQ;
`endif

    // write is dropped while reset is held so the cycle is fully abandoned
    stack_regfile #(.DEPTH(DEPTH), .AW(AW)) uRegfile (
        .clock (clock),
        .we    (we && !init_signal),
        .wAddr (wAddr),
        .wData (bus.pushData),
        .rAddr (tpPrev),
        .rData (rData)
    );

    assign bus.popData = isEmpty ? '0 : rData;
    assign bus.empty   = isEmpty;
    assign bus.full    = isFull;
    assign bus.count   = cnt;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed + random checks of pc_stack against a queue model.
// Build with or without PC_STACK_OVF_TRAP_EN; the model follows the macro.
module tb_pc_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 12;

    logic clock;
    logic init_signal;

    pc_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus();

    pc_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock       (clock),
        .init_signal (init_signal),
        .bus         (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // reference: back of queue is top of stack
    logic [AW-1:0] q[$];
    bit mOvf = 1'b0;
    bit mUnf = 1'b0;

    function automatic logic [AW-1:0] expTop();
        return (q.size() == 0) ? '0 : q[q.size()-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".popData"}, 32'(bus.popData), 32'(expTop()));
        chk({tag, ".count"},   32'(bus.count),   32'(q.size()));
        chk({tag, ".empty"},   32'(bus.empty),   32'(q.size() == 0));
        chk({tag, ".full"},    32'(bus.full),    32'(q.size() == DEPTH));
`ifdef PC_STACK_OVF_TRAP_EN
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(mOvf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(mUnf));
`endif
    endtask

    task automatic modelStep(input bit pu, input bit po, input logic [AW-1:0] d);
        if (pu && po && q.size() > 0) begin
            q[q.size()-1] = d;
        end else if (pu) begin
            if (q.size() < DEPTH) q.push_back(d);
            else begin
`ifdef PC_STACK_OVF_TRAP_EN
                mOvf = 1'b1;
`else
                void'(q.pop_front());
                q.push_back(d);
`endif
            end
        end else if (po) begin
            if (q.size() > 0) void'(q.pop_back());
            else mUnf = 1'b1;
        end
    endtask

    // drive one operation for one cycle; outputs checked mid-cycle against
    // the pre-edge model state (zero-latency pop shows current top)
    task automatic step(input string tag, input bit pu, input bit po, input logic [AW-1:0] d);
        @(negedge clock);
        bus.push = pu; bus.pop = po; bus.pushData = d;
        #1 checkAll(tag);
        @(posedge clock);
        modelStep(pu, po, d);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    task automatic popExpect(input string tag, input logic [AW-1:0] v);
        @(negedge clock);
        bus.pop = 1'b1;
        #1 chk(tag, 32'(bus.popData), 32'(v));
        @(posedge clock);
        modelStep(1'b0, 1'b1, '0);
        #1 bus.pop = 1'b0;
    endtask

    task automatic doReset();
        init_signal = 1'b1;
        q.delete(); mOvf = 1'b0; mUnf = 1'b0;
        #1 checkAll("reset");
        @(posedge clock);
        #1 init_signal = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] d;
        bit pu, po;
        bus.push = 1'b0; bus.pop = 1'b0; bus.pushData = '0;
        init_signal = 1'b1;
        #7;
        doReset();

        // async reset mid-cycle after 3 pushes
        for (int i = 0; i < 3; i++) step("rstfill", 1'b1, 1'b0, AW'($urandom));
        @(negedge clock);
        #2 init_signal = 1'b1;
        #1;
        chk("asyncRst.count",   32'(bus.count),   32'd0);
        chk("asyncRst.empty",   32'(bus.empty),   32'd1);
        chk("asyncRst.popData", 32'(bus.popData), 32'd0);
        q.delete(); mOvf = 1'b0; mUnf = 1'b0;
        @(posedge clock);
        #1 init_signal = 1'b0;
        checkAll("postRst");

        // LIFO order
        step("lifo", 1'b1, 1'b0, 12'h010);
        step("lifo", 1'b1, 1'b0, 12'h020);
        step("lifo", 1'b1, 1'b0, 12'h030);
        popExpect("lifo.pop0", 12'h030);
        popExpect("lifo.pop1", 12'h020);
        popExpect("lifo.pop2", 12'h010);
        @(negedge clock);
        chk("lifo.empty", 32'(bus.empty), 32'd1);

        // simultaneous push+pop replaces the top
        step("pp", 1'b1, 1'b0, 12'h010);
        step("pp", 1'b1, 1'b0, 12'h020);
        @(negedge clock);
        bus.push = 1'b1; bus.pop = 1'b1; bus.pushData = 12'h055;
        #1 chk("pp.sameCycle", 32'(bus.popData), 32'h020);
        @(posedge clock);
        modelStep(1'b1, 1'b1, 12'h055);
        #1 bus.push = 1'b0; bus.pop = 1'b0;
        @(negedge clock);
        chk("pp.next",  32'(bus.popData), 32'h055);
        chk("pp.count", 32'(bus.count),   32'd2);
        step("pp.drain", 1'b0, 1'b1, '0);
        step("pp.drain", 1'b0, 1'b1, '0);

        // underflow: pop on empty
        step("unf", 1'b0, 1'b1, '0);
        @(negedge clock);
        chk("unf.popData", 32'(bus.popData), 32'd0);
        chk("unf.count",   32'(bus.count),   32'd0);
`ifdef PC_STACK_OVF_TRAP_EN
        chk("unf.flag", 32'(bus.underflow), 32'd1);
`endif
        step("unf.hold", 1'b0, 1'b0, '0);
        step("unf.hold", 1'b1, 1'b0, 12'h0AA);
        step("unf.hold", 1'b0, 1'b1, '0);

        // fill to DEPTH then push once more
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, AW'(12'h100 + i));
        @(negedge clock);
        chk("fill.full",  32'(bus.full),  32'd1);
        chk("fill.count", 32'(bus.count), 32'd8);
        step("fill.ninth", 1'b1, 1'b0, 12'h1FF);
        @(negedge clock);
        chk("fill.count9", 32'(bus.count), 32'd8);
`ifdef PC_STACK_OVF_TRAP_EN
        chk("fill.top9", 32'(bus.popData), 32'h107);
        chk("fill.ovf",  32'(bus.overflow), 32'd1);
        for (int i = 7; i >= 0; i--) popExpect("fill.pop", AW'(12'h100 + i));
`else
        chk("fill.top9", 32'(bus.popData), 32'h1FF);
        popExpect("fill.pop", 12'h1FF);
        for (int i = 7; i >= 1; i--) popExpect("fill.pop", AW'(12'h100 + i));
`endif
        @(negedge clock);
        chk("fill.emptied", 32'(bus.empty), 32'd1);
`ifdef PC_STACK_OVF_TRAP_EN
        chk("unf.sticky", 32'(bus.underflow), 32'd1);
`endif

        // wrap: two pushes then one pop, walking tp across the boundary
        for (int i = 0; i < 20; i++) begin
            step("wrap", 1'b1, 1'b0, AW'($urandom));
            step("wrap", 1'b1, 1'b0, AW'($urandom));
            step("wrap", 1'b0, 1'b1, '0);
        end
        while (q.size() > 0) step("wrap.drain", 1'b0, 1'b1, '0);

        // random mix of all operations
        for (int i = 0; i < 400; i++) begin
            pu = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 2) == 0);
            d  = AW'($urandom);
            step("rand", pu, po, d);
        end

        @(negedge clock);
        checkAll("final");
        doReset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of return-address entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 12, return-address width in bits.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port init_signal  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  store pushData on top of stack this cycle (call).
REQ-006 SHALL have port pop  input  1  remove top entry this cycle (return).
REQ-007 SHALL have port pushData  input  AW  return address to store (PC+1 from the PC adder).
REQ-008 SHALL have port popData  output  AW  current top entry, combinational from registered state.
REQ-009 SHALL have port empty  output  1  count == 0.
REQ-010 SHALL have port full  output  1  count == DEPTH.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-012 SHALL keep storage as a circular buffer with a registered top pointer tp ($clog2(DEPTH) bits) and a registered count.
REQ-013 SHALL drive popData = entry[tp-1 mod DEPTH] when count > 0, and 12'h000 (all zeros, AW bits) when empty.
REQ-014 SHALL, on push only with count < DEPTH, write pushData to entry[tp], set tp <= tp+1 mod DEPTH, count <= count+1; visible on popData the next cycle.
REQ-015 SHALL, on pop only with count > 0, set tp <= tp-1 mod DEPTH, count <= count-1; popData is valid in the same cycle pop is asserted (zero-latency return).
REQ-016 SHALL, on push and pop together with count > 0, overwrite entry[tp-1] with pushData; tp and count unchanged; popData shows the old top during that cycle.
REQ-017 SHALL, on push and pop together with count == 0, behave as push only.
REQ-018 SHALL, on pop only with count == 0, leave tp, count and storage unchanged.
REQ-019 SHALL define push-when-full behaviour per REQ-026/REQ-027.
REQ-020 SHALL hold all state when neither push nor pop is asserted.

Reset
REQ-021 SHALL, while init_signal is high, force tp = 0, count = 0, empty = 1, full = 0, popData = 0, and error flags = 0, regardless of clock.
REQ-022 SHALL NOT be required to clear storage entries on reset; they are unobservable while count == 0.
REQ-023 SHALL, on reset asserted mid-operation, abandon any push/pop of that cycle; first operation after deassertion starts from an empty stack.

Configuration
REQ-024 SHALL recognise macro PC_STACK_OVF_TRAP_EN.
REQ-025 SHALL, with the macro defined, add outputs overflow (1) and underflow (1): sticky flags cleared only by reset.
REQ-026 SHALL, with the macro defined, ignore push-only when full (no state change) and set overflow; ignore pop-only when empty and set underflow; push+pop when full follows REQ-016 with no flag.
REQ-027 SHALL, without the macro, omit overflow/underflow ports; push-only when full writes entry[tp], advances tp, keeps count = DEPTH (oldest entry silently lost); pop-only when empty per REQ-018.

Structure
REQ-028 SHALL place DEPTH default, AW default, and pointer-width constant in shared package pc_stack_pkg.
REQ-029 SHALL implement storage in sub-module stack_regfile (one synchronous write port, one asynchronous read port, no reset).
REQ-030 SHALL keep pointer/count logic and flags in pc_stack itself.

Verification
REQ-031 SHALL test reset: init_signal pulse mid-cycle after 3 pushes -> count=0, empty=1, popData=0 immediately, without a clock edge.
REQ-032 SHALL test LIFO: push 12'h010, 12'h020, 12'h030, then 3 pops -> popData 12'h030, 12'h020, 12'h010 in the pop cycles; then empty=1.
REQ-033 SHALL test fill: 8 pushes of 12'h100..12'h107 -> full=1, count=8; ninth push 12'h1FF -> with macro: overflow=1, top stays 12'h107; without: top=12'h1FF, count=8, and 8 pops return 12'h1FF, 12'h107..12'h101.
REQ-034 SHALL test simultaneous push+pop with top 12'h020 and pushData 12'h055 -> popData 12'h020 that cycle, 12'h055 next, count unchanged.
REQ-035 SHALL test underflow: pop on empty -> state unchanged, popData=0; with macro underflow=1 and remains 1 until reset.
REQ-036 SHALL test wrap: alternate 20 pushes/pops across pointer boundary -> popData always equals last unpopped pushData.
